// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the program-counter unit.
package pc_unit_pkg;

   // Next-PC source select encodings
   localparam logic [1:0] PC_SRC_SEQ = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_J   = 2'd2;
   localparam logic [1:0] PC_SRC_REG = 2'd3;

   // Default vectors
   localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC    = 32'h0000_4180;
   localparam int          DEF_HIST_DEPTH = 8;

   // Resolved update cause for one cycle, in priority order below reset
   typedef enum logic [2:0] {
      UPD_HOLD = 3'd0,
      UPD_EXC  = 3'd1,
      UPD_ADEL = 3'd2,
      UPD_INT  = 3'd3,
      UPD_ERET = 3'd4,
      UPD_SEQ  = 3'd5
   } upd_e;

   function automatic logic is_entry(input upd_e c);
      return (c == UPD_EXC) || (c == UPD_ADEL) || (c == UPD_INT);
   endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Circular trace of the most recent PC values, read back newest-first.
// Latency: a write is readable the cycle after it is accepted.
// Backpressure: none; the oldest entry is overwritten once full.
module pc_trace_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    wr_ptr;
   logic [IW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + IW'(1);
         if (count != FULL)
            count <= count + (IW+1)'(1);
      end
   end

   // Contents need no reset: anything beyond count is masked on read
   always_ff @(posedge clk) begin
      if (wr_en && !reset)
         mem[wr_ptr] <= wr_data;
   end

   always_comb begin
      rd_ptr  = wr_ptr - IW'(1) - rd_idx;
      rd_data = '0;
      if ({1'b0, rd_idx} < count)
         rd_data = mem[rd_ptr];
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC mux, exception/interrupt entry, eret and PC trace.
// Latency: every PC update, EPC/EXL change and trace write lands one cycle after sampling.
// Backpressure: none; pc_write is an unconditional commit strobe.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(DEF_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(DEF_EXC_VEC),
   parameter int               HIST_DEPTH = DEF_HIST_DEPTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            pc_write,
   input  logic [1:0]                      pc_src,
   input  logic [WIDTH-1:0]                branch_off,
   input  logic [25:0]                     jump_idx,
   input  logic [WIDTH-1:0]                reg_target,
   input  logic                            exc_req,
   input  logic                            int_req,
   input  logic                            eret,
   input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
   output logic [WIDTH-1:0]                pc,
   output logic [WIDTH-1:0]                pc_plus4,
   output logic [WIDTH-1:0]                epc,
   output logic                            exl,
   output logic [WIDTH-1:0]                badaddr,
   output logic                            adel,
   output logic [WIDTH-1:0]                hist_rd_data,
   output logic [$clog2(HIST_DEPTH):0]     hist_count
);

   logic [WIDTH-1:0] npc;
   logic [WIDTH-1:0] jump_tgt;
   logic [WIDTH-1:0] pc_new;
   logic             int_pending;
   logic             int_eff;
   logic             misaligned;
   logic             pc_load;
   upd_e             cause;

   assign pc_plus4 = pc + WIDTH'(4);

   // Jump keeps the upper region bits of the sequential PC, if any exist
   generate
      if (WIDTH > 28) begin : g_jump_region
         assign jump_tgt = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00};
      end else begin : g_jump_flat
         assign jump_tgt = {jump_idx, 2'b00};
      end
   endgenerate

   always_comb begin
      npc = pc_plus4;
      case (pc_src)
         PC_SRC_SEQ: npc = pc_plus4;
         PC_SRC_BR:  npc = pc_plus4 + branch_off;
         PC_SRC_J:   npc = jump_tgt;
         PC_SRC_REG: npc = reg_target;
         default:    npc = pc_plus4;
      endcase
   end

   // A live int_req counts immediately so it can be taken on the same commit
   always_comb begin
      int_eff    = int_pending | int_req;
      misaligned = pc_write & (npc[1:0] != 2'b00);
      if (exc_req)
         cause = UPD_EXC;
      else if (misaligned)
         cause = UPD_ADEL;
      else if (pc_write && int_eff && !exl)
         cause = UPD_INT;
      else if (eret)
         cause = UPD_ERET;
      else if (pc_write)
         cause = UPD_SEQ;
      else
         cause = UPD_HOLD;
   end

   always_comb begin
      pc_new = pc;
      case (cause)
         UPD_EXC, UPD_ADEL, UPD_INT: pc_new = EXC_VEC;
         UPD_ERET:                   pc_new = epc;
         UPD_SEQ:                    pc_new = npc;
         default:                    pc_new = pc;
      endcase
   end

   assign pc_load = (cause != UPD_HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_VEC;
         epc         <= '0;
         exl         <= 1'b0;
         badaddr     <= '0;
         adel        <= 1'b0;
         int_pending <= 1'b0;
      end else begin
         pc          <= pc_new;
         adel        <= (cause == UPD_ADEL);
         int_pending <= (cause == UPD_INT) ? 1'b0 : int_eff;
         if (is_entry(cause))
            exl <= 1'b1;
         else if (cause == UPD_ERET)
            exl <= 1'b0;
         // An interrupted instruction has completed, so resume after it
         if (cause == UPD_INT)
            epc <= npc;
         else if ((cause == UPD_EXC || cause == UPD_ADEL) && !exl)
            epc <= pc;
         if (cause == UPD_ADEL)
            badaddr <= npc;
      end
   end

   pc_trace_buf #(
      .WIDTH (WIDTH),
      .DEPTH (HIST_DEPTH)
   ) u_trace (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (pc_load & ~reset),
      .wr_data (pc_new),
      .rd_idx  (hist_rd_idx),
      .rd_data (hist_rd_data),
      .count   (hist_count)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed expectations checked after each edge.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic [31:0] branch_off;
   logic [25:0] jump_idx;
   logic [31:0] reg_target;
   logic        exc_req;
   logic        int_req;
   logic        eret;
   logic [2:0]  hist_rd_idx;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] epc;
   logic        exl;
   logic [31:0] badaddr;
   logic        adel;
   logic [31:0] hist_rd_data;
   logic [3:0]  hist_count;

   int n_cmp = 0;
   int n_err = 0;

   pc_unit dut (
      .clk          (clk),
      .reset        (reset),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .branch_off   (branch_off),
      .jump_idx     (jump_idx),
      .reg_target   (reg_target),
      .exc_req      (exc_req),
      .int_req      (int_req),
      .eret         (eret),
      .hist_rd_idx  (hist_rd_idx),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .epc          (epc),
      .exl          (exl),
      .badaddr      (badaddr),
      .adel         (adel),
      .hist_rd_data (hist_rd_data),
      .hist_count   (hist_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pc_write = 1'b0; exc_req = 1'b0; int_req = 1'b0; eret = 1'b0;
   endtask

   task automatic seq();
      idle(); pc_write = 1'b1; pc_src = 2'd0;
   endtask

   task automatic rd(input logic [2:0] idx, input string tag, input logic [31:0] exp);
      hist_rd_idx = idx;
      #1;
      chk(tag, hist_rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; idle(); pc_src = 2'd0; branch_off = '0; jump_idx = '0;
      reg_target = '0; hist_rd_idx = '0;
      tick(); tick();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_pc_plus4", pc_plus4, 32'h3004);
      chk("rst_epc", epc, 32'h0);
      chk("rst_exl", exl, 32'h0);
      chk("rst_adel", adel, 32'h0);
      chk("rst_badaddr", badaddr, 32'h0);
      chk("rst_hist_count", hist_count, 32'h0);
      rd(3'd0, "rst_hist_rd0", 32'h0);

      // Sequential
      reset = 1'b0; seq();
      tick(); chk("seq_pc1", pc, 32'h3004);
      tick(); chk("seq_pc2", pc, 32'h3008);
      tick(); chk("seq_pc3", pc, 32'h300C);
      chk("seq_hist_count", hist_count, 32'd3);
      rd(3'd0, "seq_hist_rd0", 32'h300C);
      rd(3'd2, "seq_hist_rd2", 32'h3004);
      rd(3'd3, "seq_hist_rd3_masked", 32'h0);

      // Branch / jump / register
      tick(); chk("seq_pc4", pc, 32'h3010);
      pc_src = 2'd1; branch_off = 32'hFFFF_FFF0;
      tick(); chk("branch_back", pc, 32'h3004);
      pc_src = 2'd2; jump_idx = 26'h0000C40;
      tick(); chk("jump", pc, 32'h3100);
      pc_src = 2'd3; reg_target = 32'h3200;
      tick(); chk("jr", pc, 32'h3200);

      // Exceptions
      reg_target = 32'h3020;
      tick(); chk("jr_3020", pc, 32'h3020);
      idle(); exc_req = 1'b1;
      tick();
      chk("exc_pc", pc, 32'h4180);
      chk("exc_epc", epc, 32'h3020);
      chk("exc_exl", exl, 32'd1);
      tick();
      chk("exc2_epc_kept", epc, 32'h3020);
      chk("exc2_pc", pc, 32'h4180);
      idle(); eret = 1'b1;
      tick();
      chk("eret_pc", pc, 32'h3020);
      chk("eret_exl", exl, 32'd0);

      // Misaligned register target
      idle(); pc_write = 1'b1; pc_src = 2'd3; reg_target = 32'h3202;
      tick();
      chk("adel_pc", pc, 32'h4180);
      chk("adel_pulse", adel, 32'd1);
      chk("adel_badaddr", badaddr, 32'h3202);
      chk("adel_exl", exl, 32'd1);
      idle(); reg_target = 32'h3203;
      tick();
      chk("adel_pulse_end", adel, 32'd0);
      chk("misaligned_nowrite_pc", pc, 32'h4180);
      chk("misaligned_nowrite_badaddr", badaddr, 32'h3202);

      // Interrupt held off while EXL, taken after eret
      idle(); eret = 1'b1;
      tick(); chk("eret2_pc", pc, 32'h3020);
      idle(); pc_write = 1'b1; pc_src = 2'd3; reg_target = 32'h3040;
      tick(); chk("jr_3040", pc, 32'h3040);
      idle(); exc_req = 1'b1;
      tick(); chk("exc3_epc", epc, 32'h3040);
      seq(); int_req = 1'b1;
      tick();
      chk("int_blocked_pc", pc, 32'h4184);
      chk("int_blocked_epc", epc, 32'h3040);
      idle(); eret = 1'b1; pc_write = 1'b1; pc_src = 2'd0;
      tick();
      chk("eret_with_write_pc", pc, 32'h3040);
      chk("eret_with_write_exl", exl, 32'd0);
      seq();
      tick();
      chk("int_taken_pc", pc, 32'h4180);
      chk("int_taken_epc", epc, 32'h3044);
      chk("int_taken_exl", exl, 32'd1);
      idle(); eret = 1'b1;
      tick(); chk("eret3_pc", pc, 32'h3044);
      seq();
      tick(); chk("int_cleared_pc", pc, 32'h3048);
      seq(); int_req = 1'b1;
      tick();
      chk("int_same_cycle_pc", pc, 32'h4180);
      chk("int_same_cycle_epc", epc, 32'h304C);

      // Reset wins over exception entry
      idle(); reset = 1'b1; exc_req = 1'b1;
      tick();
      chk("rst_exc_pc", pc, 32'h3000);
      chk("rst_exc_exl", exl, 32'd0);
      chk("rst_exc_hist_count", hist_count, 32'd0);

      // Trace wrap-around
      reset = 1'b0; seq();
      for (int i = 0; i < 10; i++) tick();
      chk("wrap_pc", pc, 32'h3028);
      chk("wrap_hist_count", hist_count, 32'd8);
      rd(3'd0, "wrap_rd0", 32'h3028);
      rd(3'd7, "wrap_rd7", 32'h300C);
      idle(); reset = 1'b1;
      tick();
      chk("wrap_rst_count", hist_count, 32'd0);
      rd(3'd0, "wrap_rst_rd0", 32'h0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
